layer_cu: RTL and testbench

LAYER_CU -- requirements
Module: layer_cu

---
 rtl/layer_cu.sv | 200 ++++++++++++++++++++
 tb/tb_layer_cu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/layer_cu.sv
// Purpose: sequencer for one fully-connected layer; walks output neurons in groups of LANES, driving MAC kernel controls and result writes.
// Latency: per group 1 INIT + in_len MAC + 1 BIAS (if built) + Lg WRITE cycles, then a single DONE cycle; outputs are registered.
// Backpressure: none; memories are assumed single-cycle, and go is ignored while busy. Optional bias phase: define LAYER_CU_BIAS_EN.
module layer_cu #(
    parameter int ADDR_W = 32,
    parameter int LANES  = 4,
    parameter int LANE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              relu,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [ADDR_W-1:0] weight_address,
    input  logic [ADDR_W-1:0] result_address,
    input  logic [ADDR_W-1:0] in_len,
    input  logic [ADDR_W-1:0] out_len,
    output logic              busy,
    output logic              done,
    output logic              init,
    output logic              en,
    output logic              bias_en,
    output logic              mode,
    output logic [ADDR_W-1:0] data_idx,
    output logic [ADDR_W-1:0] weight_idx,
    output logic [ADDR_W-1:0] result_idx,
    output logic              write_enable,
    output logic [LANE_W-1:0] lane_sel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_MAC   = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LANES_A = ADDR_W'(LANES);

    state_t              state;
    logic                relu_r;
    logic [ADDR_W-1:0]   data_addr_r;
    logic [ADDR_W-1:0]   weight_addr_r;
    logic [ADDR_W-1:0]   res_addr_r;
    logic [ADDR_W-1:0]   in_len_r;
    logic [ADDR_W-1:0]   out_len_r;
    logic [ADDR_W-1:0]   grp_base;   // g*LANES, first neuron of the current group
    logic [ADDR_W-1:0]   kcnt;       // MAC cycle within the group
    logic [ADDR_W-1:0]   lg;         // lanes in the current group
    logic                first_w;    // next enabled cycle is the first of the layer

    logic [ADDR_W-1:0]   rem;
    logic [ADDR_W-1:0]   lg_calc;
    logic [ADDR_W-1:0]   w_next;
    logic                last_lane;
    logic                last_mac;

    // Group sizing and next weight address; the weight stream runs unbroken across groups
    always_comb begin
        rem       = out_len_r - grp_base;
        lg_calc   = (rem < LANES_A) ? rem : LANES_A;
        w_next    = first_w ? weight_addr_r : (weight_idx + ONE);
        last_lane = (ADDR_W'(lane_sel) == (lg - ONE));
        last_mac  = (kcnt == (in_len_r - ONE));
    end

    // Layer sequencer; every output is registered alongside the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            relu_r        <= 1'b0;
            data_addr_r   <= '0;
            weight_addr_r <= '0;
            res_addr_r    <= '0;
            in_len_r      <= '0;
            out_len_r     <= '0;
            grp_base      <= '0;
            kcnt          <= '0;
            lg            <= '0;
            first_w       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            init          <= 1'b0;
            en            <= 1'b0;
            bias_en       <= 1'b0;
            mode          <= 1'b0;
            data_idx      <= '0;
            weight_idx    <= '0;
            result_idx    <= '0;
            write_enable  <= 1'b0;
            lane_sel      <= '0;
        end else begin
            init         <= 1'b0;
            en           <= 1'b0;
            bias_en      <= 1'b0;
            write_enable <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        relu_r        <= relu;
                        data_addr_r   <= data_address;
                        weight_addr_r <= weight_address;
                        res_addr_r    <= result_address;
                        in_len_r      <= in_len;
                        out_len_r     <= out_len;
                        grp_base      <= '0;
                        first_w       <= 1'b1;
                        busy          <= 1'b1;
                        mode          <= relu;
                        init          <= 1'b1;
                        state         <= S_INIT;
                    end
                end
                S_INIT: begin
                    lg <= lg_calc;
                    if (out_len_r == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (in_len_r != '0) begin
                        kcnt       <= '0;
                        data_idx   <= data_addr_r;
                        weight_idx <= w_next;
                        first_w    <= 1'b0;
                        en         <= 1'b1;
                        state      <= S_MAC;
                    end else begin
`ifdef LAYER_CU_BIAS_EN
                        weight_idx <= w_next;
                        first_w    <= 1'b0;
                        en         <= 1'b1;
                        bias_en    <= 1'b1;
                        state      <= S_BIAS;
`else
                        lane_sel     <= '0;
                        result_idx   <= res_addr_r + grp_base;
                        write_enable <= 1'b1;
                        state        <= S_WRITE;
`endif
                    end
                end
                S_MAC: begin
                    if (!last_mac) begin
                        kcnt       <= kcnt + ONE;
                        data_idx   <= data_idx + ONE;
                        weight_idx <= w_next;
                        en         <= 1'b1;
                    end else begin
`ifdef LAYER_CU_BIAS_EN
                        weight_idx <= w_next;
                        en         <= 1'b1;
                        bias_en    <= 1'b1;
                        state      <= S_BIAS;
`else
                        lane_sel     <= '0;
                        result_idx   <= res_addr_r + grp_base;
                        write_enable <= 1'b1;
                        state        <= S_WRITE;
`endif
                    end
                end
                S_BIAS: begin
                    lane_sel     <= '0;
                    result_idx   <= res_addr_r + grp_base;
                    write_enable <= 1'b1;
                    state        <= S_WRITE;
                end
                S_WRITE: begin
                    if (!last_lane) begin
                        lane_sel     <= lane_sel + LANE_W'(1);
                        result_idx   <= result_idx + ONE;
                        write_enable <= 1'b1;
                    end else if (rem > LANES_A) begin
                        // More neurons remain beyond this group
                        grp_base <= grp_base + LANES_A;
                        init     <= 1'b1;
                        state    <= S_INIT;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    mode  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    mode  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_cu.sv
// Purpose: directed self-checking bench for layer_cu (LANES=4, ADDR_W=32).
// Latency: samples on the falling edge; sample n after go shows the cycle ending at edge t0+n+1.
// Backpressure: not applicable; expectations adapt to LAYER_CU_BIAS_EN.
module tb_layer_cu;

    logic        clk;
    logic        rst;
    logic        go;
    logic        relu;
    logic [31:0] data_address;
    logic [31:0] weight_address;
    logic [31:0] result_address;
    logic [31:0] in_len;
    logic [31:0] out_len;
    logic        busy;
    logic        done;
    logic        init;
    logic        en;
    logic        bias_en;
    logic        mode;
    logic [31:0] data_idx;
    logic [31:0] weight_idx;
    logic [31:0] result_idx;
    logic        write_enable;
    logic [5:0]  lane_sel;

    int checks = 0;
    int errors = 0;

`ifdef LAYER_CU_BIAS_EN
    localparam int A_DONE = 25, A_BIAS = 3, A_LASTW = 1011;
    localparam int B_DONE = 6,  B_EN = 1;
    localparam int C_DONE = 8,  E_DONE = 9;
`else
    localparam int A_DONE = 22, A_BIAS = 0, A_LASTW = 1008;
    localparam int B_DONE = 5,  B_EN = 0;
    localparam int C_DONE = 7,  E_DONE = 8;
`endif

    `define CHK(tag, obs, exp) \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
        end

    layer_cu #(.ADDR_W(32), .LANES(4), .LANE_W(6)) dut (
        .clk(clk), .rst(rst), .go(go), .relu(relu),
        .data_address(data_address), .weight_address(weight_address),
        .result_address(result_address), .in_len(in_len), .out_len(out_len),
        .busy(busy), .done(done), .init(init), .en(en), .bias_en(bias_en),
        .mode(mode), .data_idx(data_idx), .weight_idx(weight_idx),
        .result_idx(result_idx), .write_enable(write_enable), .lane_sel(lane_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trace of one layer run
    int          done_n, done_cnt, n_wr, bursts, en_cnt, bias_cnt, n_mac, mode_bad;
    logic        init0, en0, prev_we, relu_exp;
    logic [31:0] last_w;
    logic [31:0] wr_res [0:15];
    logic [5:0]  wr_lane [0:15];
    logic [31:0] mac_data [0:15];

    task automatic run_layer(input int max_n, input bit rego);
        done_n = -1; done_cnt = 0; n_wr = 0; bursts = 0; en_cnt = 0;
        bias_cnt = 0; n_mac = 0; mode_bad = 0; prev_we = 1'b0; last_w = '0;
        relu_exp = relu;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int n = 0; n < max_n; n++) begin
            if (n == 0) begin init0 = init; en0 = en; end
            if (done) begin done_cnt++; done_n = n; end
            if (write_enable && n_wr < 16) begin
                wr_res[n_wr] = result_idx; wr_lane[n_wr] = lane_sel; n_wr++;
            end
            if (write_enable && !prev_we) bursts++;
            prev_we = write_enable;
            if (en) begin en_cnt++; last_w = weight_idx; end
            if (bias_en) bias_cnt++;
            if (en && !bias_en && n_mac < 16) begin mac_data[n_mac] = data_idx; n_mac++; end
            if (busy && mode !== relu_exp) mode_bad++;
            if (rego && n == 1) begin go = 1'b1; data_address = 32'd900; end
            if (rego && n == 2) go = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; relu = 1'b0;
        data_address = '0; weight_address = '0; result_address = '0;
        in_len = '0; out_len = '0;
        #1;
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_weight_idx", weight_idx, 32'd0)
        `CHK("rst_lane_sel", lane_sel, 6'd0)
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Three groups: 4, 4 and 2 lanes
        relu = 1'b1; data_address = 32'd100; weight_address = 32'd1000;
        result_address = 32'd2000; in_len = 32'd3; out_len = 32'd10;
        run_layer(40, 1'b0);
        `CHK("A_init_first", init0, 1'b1)
        `CHK("A_en_first", en0, 1'b0)
        `CHK("A_done_cycle", done_n, A_DONE)
        `CHK("A_done_count", done_cnt, 1)
        `CHK("A_writes", n_wr, 10)
        `CHK("A_bursts", bursts, 3)
        for (int i = 0; i < 10; i++) begin
            `CHK("A_result_idx", wr_res[i], 32'd2000 + 32'(i))
            `CHK("A_lane_sel", wr_lane[i], 6'(i % 4))
        end
        `CHK("A_mac_count", n_mac, 9)
        for (int i = 0; i < 9; i++) begin
            `CHK("A_data_idx", mac_data[i], 32'd100 + 32'(i % 3))
        end
        `CHK("A_bias_cycles", bias_cnt, A_BIAS)
        `CHK("A_last_weight", last_w, 32'(A_LASTW))
        `CHK("A_mode_busy", mode_bad, 0)
        `CHK("A_idle_busy", busy, 1'b0)
        `CHK("A_idle_mode", mode, 1'b0)

        // Empty input vector
        relu = 1'b0; in_len = 32'd0; out_len = 32'd4; result_address = 32'd300;
        run_layer(12, 1'b0);
        `CHK("B_done_cycle", done_n, B_DONE)
        `CHK("B_en_cycles", en_cnt, B_EN)
        `CHK("B_writes", n_wr, 4)
        `CHK("B_last_result", wr_res[3], 32'd303)

        // Empty layer
        out_len = 32'd0;
        run_layer(6, 1'b0);
        `CHK("Z_done_cycle", done_n, 1)
        `CHK("Z_writes", n_wr, 0)
        `CHK("Z_en_cycles", en_cnt, 0)

        // go re-pulsed during MAC must be ignored
        data_address = 32'd50; in_len = 32'd4; out_len = 32'd2;
        run_layer(30, 1'b1);
        `CHK("C_done_count", done_cnt, 1)
        `CHK("C_done_cycle", done_n, C_DONE)
        `CHK("C_mac_count", n_mac, 4)
        for (int i = 0; i < 4; i++) begin
            `CHK("C_data_idx", mac_data[i], 32'd50 + 32'(i))
        end

        // Reset during WRITE aborts the layer
        relu = 1'b1; data_address = 32'd7; in_len = 32'd1; out_len = 32'd4;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 20 && !write_enable; n++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        `CHK("D_reached_write", write_enable, 1'b1)
        `CHK("D_no_done", done_cnt, 0)
        rst = 1'b1;
        #1;
        `CHK("D_rst_busy", busy, 1'b0)
        `CHK("D_rst_we", write_enable, 1'b0)
        `CHK("D_rst_result_idx", result_idx, 32'd0)
        `CHK("D_rst_mode", mode, 1'b0)
        @(negedge clk);
        rst = 1'b0;

        // Full layer after reset, with data address wrap
        relu = 1'b0; data_address = 32'hFFFF_FFFE; weight_address = 32'd10;
        result_address = 32'd20; in_len = 32'd4; out_len = 32'd3;
        run_layer(16, 1'b0);
        `CHK("E_done_cycle", done_n, E_DONE)
        `CHK("E_writes", n_wr, 3)
        `CHK("E_result_last", wr_res[2], 32'd22)
        `CHK("E_data0", mac_data[0], 32'hFFFF_FFFE)
        `CHK("E_data1", mac_data[1], 32'hFFFF_FFFF)
        `CHK("E_data2", mac_data[2], 32'h0000_0000)
        `CHK("E_data3", mac_data[3], 32'h0000_0001)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
